data_memory_responder: RTL
==========================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address width (memory depth 2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response valid; legal range 1..15.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 reqValid  input  1  memory-stage request present.
REQ-007 reqReady  output  1  responder can accept a request.
REQ-008 reqWrite  input  1  1 = store, 0 = load.
REQ-009 reqAddress  input  32  byte address.
REQ-010 reqWriteData  input  32  store data.
REQ-011 reqByteEnable  input  4  store byte lanes; bit i enables bits [8i+7:8i].
REQ-012 respValid  output  1  response present.
REQ-013 respReady  input  1  memory stage accepts response.
REQ-014 respReadData  output  32  load data; 0 for stores.
REQ-015 respError  output  1  access rejected (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESPOND; one outstanding request maximum.
REQ-017 SHALL drive reqReady=1 only in IDLE; respValid=1 only in RESPOND.
REQ-018 SHALL accept a request on a rising edge with reqValid=1 and reqReady=1, capture reqWrite/reqAddress/reqWriteData/reqByteEnable, load the latency counter with LATENCY-1, and move to WAIT.
REQ-019 In WAIT SHALL decrement the counter each cycle; on the edge where the counter is 0 SHALL commit the store (enabled lanes only) or capture the load word, then enter RESPOND.
REQ-020 SHALL assert respValid exactly LATENCY cycles after the accepting edge.
REQ-021 SHALL index memory with captured reqAddress[ADDR_WIDTH+1:2].
REQ-022 SHALL hold respValid, respReadData, respError stable in RESPOND until an edge with respReady=1, then return to IDLE (reqReady=1 the following cycle).
REQ-023 Input changes outside an accepting edge SHALL have no effect; reqValid while busy SHALL be ignored, not queued.
REQ-024 A load following a store to the same word SHALL return the post-store data.
REQ-025 respReadData SHALL be 0 for store responses and for error responses.

Reset
REQ-026 On reset low SHALL immediately enter IDLE: reqReady=1 (once reset released), respValid=0, respReadData=0, respError=0, counter=0.
REQ-027 Reset asserted during WAIT SHALL abort the request; an uncommitted store SHALL not modify memory.
REQ-028 Memory array contents SHALL not be reset.

Configuration
REQ-029 Macro DATA_MEMORY_RESPONDER_CHECK_EN SHALL enable access checking.
REQ-030 With the macro defined: reqAddress[1:0]!=0 or reqAddress[31:ADDR_WIDTH+2]!=0 SHALL produce respError=1, no memory write, respReadData=0, same LATENCY timing.
REQ-031 Without the macro: respError SHALL be constant 0; address bits [1:0] and above ADDR_WIDTH+1 SHALL be ignored (address wraps).

Verification
REQ-032 Store 0xDEADBEEF to 0x10, byteEnable 4'hF, then load 0x10 -> load respValid LATENCY cycles after acceptance, respReadData=0xDEADBEEF, respError=0.
REQ-033 Word 0x10 = 0x11223344; store 0xAABBCCDD with byteEnable 4'b0101; load 0x10 -> 0x11BB33DD.
REQ-034 Hold respReady=0 for 5 cycles in RESPOND -> respValid and data stable, reqReady=0, second reqValid ignored; respReady=1 -> reqReady=1 next cycle.
REQ-035 Store 0x55 to 0x20, assert reset during WAIT before counter reaches 0, re-store nothing, load 0x20 -> prior contents unchanged; all outputs at reset values during reset.
REQ-036 With DATA_MEMORY_RESPONDER_CHECK_EN: store to 0x13 -> respError=1, respReadData=0, memory unchanged; without it: same store writes word 0x10, respError=0.
REQ-037 LATENCY=1 and LATENCY=15 builds: back-to-back loads with respReady=1 -> one response per LATENCY+2 cycles, correct data.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Bus between the memory pipeline stage and the data memory responder.
// The request channel is a valid/ready handshake. The response channel is a
// valid/ready handshake that carries load data and an error flag.
interface data_memory_responder_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic [3:0]  reqByteEnable;
    logic        respValid;
    logic        respReady;
    logic [31:0] respReadData;
    logic        respError;

    // Memory stage side.
    modport master (
        output reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, respReady,
        input  reqReady, respValid, respReadData, respError
    );

    // Responder side.
    modport slave (
        input  reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, respReady,
        output reqReady, respValid, respReadData, respError
    );
endinterface

// File: rtl/data_memory_responder.sv
// Single-outstanding data memory responder with a fixed request-to-response
// latency. Stores are committed with per-byte lane enables at the end of the
// wait period, so a reset during the wait leaves memory untouched.
// Optional feature: define DATA_MEMORY_RESPONDER_CHECK_EN to reject misaligned
// or out-of-range addresses with respError. Without it, the address wraps.
module data_memory_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2   // legal range 1..15
) (
    input  logic                   clock,
    input  logic                   reset,   // asynchronous, active low
    data_memory_responder_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StRespond} stateE;

    localparam logic [3:0] LoadCount = 4'(LATENCY - 1);

    stateE                 stateQ, stateD;
    logic [3:0]            counterQ, counterD;
    logic                  capWriteQ;
    logic [ADDR_WIDTH-1:0] capIndexQ;
    logic [31:0]           capDataQ;
    logic [3:0]            capByteEnableQ;
    logic                  capErrorQ;
    logic [31:0]           readDataQ;
    logic                  errorQ;
    logic                  accept;
    logic                  commit;
    logic                  reqError;
    logic [31:0]           mergedWord;

    logic [31:0] mem [2**ADDR_WIDTH];

`ifdef DATA_MEMORY_RESPONDER_CHECK_EN
    assign reqError = (bus.reqAddress[1:0] != 2'b00) ||
                      (bus.reqAddress[31:ADDR_WIDTH+2] != '0);
`else
    // Byte-offset and high address bits are deliberately ignored here.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.reqAddress[1:0], bus.reqAddress[31:ADDR_WIDTH+2]};
    assign reqError = 1'b0;
`endif

    // Next-state logic for the request/wait/respond sequence.
    always_comb begin
        stateD   = stateQ;
        counterD = counterQ;
        accept   = 1'b0;
        commit   = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (bus.reqValid) begin
                    accept   = 1'b1;
                    counterD = LoadCount;
                    stateD   = StWait;
                end
            end
            StWait: begin
                if (counterQ == 4'd0) begin
                    commit = 1'b1;
                    stateD = StRespond;
                end else begin
                    counterD = counterQ - 4'd1;
                end
            end
            StRespond: begin
                if (bus.respReady) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Byte-lane merge of captured store data over the current memory word.
    always_comb begin
        mergedWord = mem[capIndexQ];
        for (int i = 0; i < 4; i++) begin
            if (capByteEnableQ[i]) begin
                mergedWord[8*i +: 8] = capDataQ[8*i +: 8];
            end
        end
    end

    // State, counter, request capture and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ         <= StIdle;
            counterQ       <= 4'd0;
            capWriteQ      <= 1'b0;
            capIndexQ      <= '0;
            capDataQ       <= 32'd0;
            capByteEnableQ <= 4'd0;
            capErrorQ      <= 1'b0;
            readDataQ      <= 32'd0;
            errorQ         <= 1'b0;
        end else begin
            stateQ   <= stateD;
            counterQ <= counterD;
            if (accept) begin
                capWriteQ      <= bus.reqWrite;
                capIndexQ      <= bus.reqAddress[ADDR_WIDTH+1:2];
                capDataQ       <= bus.reqWriteData;
                capByteEnableQ <= bus.reqByteEnable;
                capErrorQ      <= reqError;
            end
            if (commit) begin
                readDataQ <= (capWriteQ || capErrorQ) ? 32'd0 : mem[capIndexQ];
                errorQ    <= capErrorQ;
            end else if (stateQ == StRespond && bus.respReady) begin
                readDataQ <= 32'd0;
                errorQ    <= 1'b0;
            end
        end
    end

    // Memory array; not reset, written only on a committed, error-free store.
    always_ff @(posedge clock) begin
        if (commit && capWriteQ && !capErrorQ) begin
            mem[capIndexQ] <= mergedWord;
        end
    end

    assign bus.reqReady     = (stateQ == StIdle);
    assign bus.respValid    = (stateQ == StRespond);
    assign bus.respReadData = readDataQ;
    assign bus.respError    = errorQ;
endmodule
